// File: rtl/bsg_xnor_popcount_acc.sv
// bsg_xnor_popcount_acc
// ---------------------
// Streaming XNOR-popcount accumulator for binary-neural-net / similarity
// datapaths. Each accepted beat counts the bit positions where a_i and b_i
// agree and adds that count into a running sum. A beat flagged last_i closes
// the vector, and the finished sum is offered on a valid/yumi output.
//
// Pipeline:
//   Stage P registers the popcount and the last flag of an accepted beat.
//   Stage A folds that count into the accumulator. On a last beat it loads
//   the output register instead.
//
// Parameters:
//   width_p      operand width in bits (>= 1)
//   acc_width_p  accumulator / result width (>= $clog2(width_p+1))
//
// Ports:
//   clk_i       clock
//   reset_i     synchronous, active-high reset
//   v_i         input beat valid
//   ready_o     block can accept a beat (transfer on v_i & ready_o)
//   a_i, b_i    operands
//   last_i      beat closes the current vector
//   v_o         result valid
//   data_o      match count of the completed vector
//   overflow_o  completed vector's sum did not fit in acc_width_p bits
//   yumi_i      consumer takes the result (only meaningful while v_o = 1)
//
// Build option:
//   BSG_XNOR_POPC_ACC_SAT_EN  when defined, the sum clamps to all-ones on
//                             carry-out. Otherwise the sum wraps. overflow_o
//                             is reported in both builds.

module bsg_xnor_popcount_acc #(
  parameter int width_p     = 16,
  parameter int acc_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic                   last_i,
  output logic                   v_o,
  output logic [acc_width_p-1:0] data_o,
  output logic                   overflow_o,
  input  logic                   yumi_i
);

  localparam int pop_width_lp = $clog2(width_p + 1);

  // Elaboration-time parameter guards.
  if (width_p < 1) begin : g_bad_width
    $error("bsg_xnor_popcount_acc: width_p must be >= 1");
  end
  if (acc_width_p < pop_width_lp) begin : g_bad_acc_width
    $error("bsg_xnor_popcount_acc: acc_width_p must be >= $clog2(width_p+1)");
  end

  logic                    xfer;
  logic [width_p-1:0]      match;
  logic [pop_width_lp-1:0] pop_d, pop_q;
  logic                    pv_q, last_q;

  logic [acc_width_p-1:0]  acc_d, acc_q;
  logic                    first_d, first_q;
  logic                    ovf_d, ovf_q;
  logic [acc_width_p-1:0]  data_d, data_q;
  logic                    ovf_out_d, ovf_out_q;
  logic                    v_d, v_q;

  logic [acc_width_p-1:0]  base;
  logic [acc_width_p:0]    sum_full;
  logic                    carry;
  logic [acc_width_p-1:0]  sum;

  // A last beat in Stage P would collide with a pending result, so input
  // acceptance also stalls while one is on its way to the output.
  assign ready_o = ~v_q & ~(pv_q & last_q);
  assign xfer    = v_i & ready_o;
  assign match   = ~(a_i ^ b_i);

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < width_p; i++) begin
      pop_d = pop_d + pop_width_lp'(match[i]);
    end
  end

  // Stage P register. pop_q/last_q are only meaningful while pv_q is set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pv_q   <= 1'b0;
      last_q <= 1'b0;
      pop_q  <= '0;
    end else begin
      pv_q <= xfer;
      if (xfer) begin
        pop_q  <= pop_d;
        last_q <= last_i;
      end
    end
  end

  // The first beat of a vector starts from zero rather than clearing the
  // accumulator separately. This lets vectors stream back to back.
  always_comb begin
    base     = first_q ? '0 : acc_q;
    sum_full = {1'b0, base} + (acc_width_p + 1)'(pop_q);
    carry    = sum_full[acc_width_p];
`ifdef BSG_XNOR_POPC_ACC_SAT_EN
    // Once clamped, later adds carry again (or add zero), so it stays clamped.
    sum      = carry ? '1 : sum_full[acc_width_p-1:0];
`else
    sum      = sum_full[acc_width_p-1:0];
`endif
  end

  always_comb begin
    acc_d     = acc_q;
    first_d   = first_q;
    ovf_d     = ovf_q;
    data_d    = data_q;
    ovf_out_d = ovf_out_q;
    v_d       = v_q & ~yumi_i;
    if (pv_q) begin
      if (!last_q) begin
        acc_d   = sum;
        first_d = 1'b0;
        ovf_d   = ovf_q | carry;
      end else begin
        data_d    = sum;
        ovf_out_d = ovf_q | carry;
        v_d       = 1'b1;
        first_d   = 1'b1;
        ovf_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      ovf_out_q <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      first_q   <= first_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      ovf_out_q <= ovf_out_d;
      v_q       <= v_d;
    end
  end

  assign v_o        = v_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_out_q;

endmodule

// File: tb/tb_bsg_xnor_popcount_acc.sv
// Testbench for bsg_xnor_popcount_acc.
// Two instances share one input stream: the default 16-bit accumulator and a
// 5-bit accumulator, which exercises overflow. A transaction-level model
// tracks vector sums and the valid/ready timing. The checker compares both
// instances on every cycle, and directed scenarios add literal expectations.
module tb_bsg_xnor_popcount_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1;
  logic        v_i     = 1'b0;
  logic        last_i  = 1'b0;
  logic        yumi_i  = 1'b0;
  logic [15:0] a_i     = '0;
  logic [15:0] b_i     = '0;

  logic        ready16, v16, ovf16;
  logic [15:0] data16;
  logic        ready5, v5, ovf5;
  logic [4:0]  data5;

  bsg_xnor_popcount_acc #(.width_p(16), .acc_width_p(16)) dut16 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready16),
    .a_i(a_i), .b_i(b_i), .last_i(last_i), .v_o(v16), .data_o(data16),
    .overflow_o(ovf16), .yumi_i(yumi_i)
  );

  bsg_xnor_popcount_acc #(.width_p(16), .acc_width_p(5)) dut5 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready5),
    .a_i(a_i), .b_i(b_i), .last_i(last_i), .v_o(v5), .data_o(data5),
    .overflow_o(ovf5), .yumi_i(yumi_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int yumiMode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected results for a vector whose true (unbounded) sum is s.
  function automatic logic [31:0] expData16(int s);
    return s & 32'hFFFF;
  endfunction
  function automatic logic [31:0] expOvf16(int s);
    return (s > 65535) ? 32'd1 : 32'd0;
  endfunction
  function automatic logic [31:0] expData5(int s);
`ifdef BSG_XNOR_POPC_ACC_SAT_EN
    return (s > 31) ? 32'd31 : 32'(s);
`else
    return s & 32'h1F;
`endif
  endfunction
  function automatic logic [31:0] expOvf5(int s);
    return (s > 31) ? 32'd1 : 32'd0;
  endfunction

  // Consumer: 0 never takes, 1 takes immediately, 2 takes at random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (yumiMode)
        1:       yumi_i = v16;
        2:       yumi_i = v16 & ($urandom_range(0, 2) == 0);
        default: yumi_i = 1'b0;
      endcase
    end
  end

  // Reference model and per-cycle compare, sampled at the falling edge.
  logic mV = 1'b0, lastPrev = 1'b0, live = 1'b0, mReady;
  int   runSum = 0, pendSum = 0, mRes = 0, popv = 0;

  initial begin
    forever begin
      @(negedge clk);
      mReady = !mV && !lastPrev;
      if (live) begin
        checkOutput("ready_o", 32'(ready16), 32'(mReady));
        checkOutput("ready_o_w5", 32'(ready5), 32'(mReady));
        checkOutput("v_o", 32'(v16), 32'(mV));
        checkOutput("v_o_w5", 32'(v5), 32'(mV));
        if (mV) begin
          checkOutput("data_o", 32'(data16), expData16(mRes));
          checkOutput("overflow_o", 32'(ovf16), expOvf16(mRes));
          checkOutput("data_o_w5", 32'(data5), expData5(mRes));
          checkOutput("overflow_o_w5", 32'(ovf5), expOvf5(mRes));
        end
        if (yumi_i && !mV && !reset_i)
          $display("[TB] protocol violation: yumi_i while v_o low (cycle %0d)", cyc);
      end
      if (reset_i) begin
        mV = 1'b0; lastPrev = 1'b0; runSum = 0; mRes = 0; live = 1'b1;
      end else if (live) begin
        if (lastPrev) begin
          mV = 1'b1;
          mRes = pendSum;
        end else if (mV && yumi_i) begin
          mV = 1'b0;
        end
        lastPrev = 1'b0;
        if (v_i && mReady) begin
          popv = $countones(~(a_i ^ b_i));
          if (last_i) begin
            pendSum = runSum + popv;
            runSum = 0;
            lastPrev = 1'b1;
          end else begin
            runSum = runSum + popv;
          end
        end
      end
    end
  end

  // Called just after a rising edge; holds the beat until it is accepted.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic last,
                               output int xferCyc);
    logic acc;
    xferCyc = -1;
    v_i = 1'b1; a_i = a; b_i = b; last_i = last;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      acc = ready16;
      if (acc) xferCyc = cyc;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (xferCyc < 0) checkOutput("accept_timeout", 32'd0, 32'd1);
    v_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic waitResult(output int seen, output logic [15:0] d16, output logic o16,
                            output logic [4:0] d5, output logic o5);
    seen = -1; d16 = '0; o16 = 1'b0; d5 = '0; o5 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (v16 === 1'b1) begin
        seen = cyc; d16 = data16; o16 = ovf16; d5 = data5; o5 = ovf5;
        break;
      end
    end
    if (seen < 0) checkOutput("result_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    v_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset();
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    int t1, t2, t3, r, yc;
    logic [15:0] d16;
    logic [4:0]  d5;
    logic        o16, o5;
    logic [31:0] rnd;
    logic [15:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'(ready16), 32'd1);
    checkOutput("reset_v", 32'(v16), 32'd0);
    checkOutput("reset_data", 32'(data16), 32'd0);
    checkOutput("reset_ovf", 32'(ovf16), 32'd0);
    @(posedge clk);
    #1;

    // Single beat, all bits match.
    yumiMode = 1;
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, t1);
    waitResult(r, d16, o16, d5, o5);
    checkOutput("single_latency", 32'(r - t1), 32'd2);
    checkOutput("single_data", 32'(d16), 32'd16);
    checkOutput("single_ovf", 32'(o16), 32'd0);

    // Single beat, half the bits match.
    applyStimulus(16'h00FF, 16'h0000, 1'b1, t1);
    waitResult(r, d16, o16, d5, o5);
    checkOutput("half_data", 32'(d16), 32'd8);

    // Three-beat vector streamed back to back: 16 + 0 + 12.
    applyStimulus(16'h1234, 16'h1234, 1'b0, t1);
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, t2);
    applyStimulus(16'hF0F0, 16'hF000, 1'b1, t3);
    checkOutput("b2b_gap12", 32'(t2 - t1), 32'd1);
    checkOutput("b2b_gap23", 32'(t3 - t2), 32'd1);
    waitResult(r, d16, o16, d5, o5);
    checkOutput("three_latency", 32'(r - t3), 32'd2);
    checkOutput("three_data", 32'(d16), 32'd28);
    checkOutput("three_data_w5", 32'(d5), 32'd28);

    // Backpressure: result held while the next beat waits.
    yumiMode = 0;
    applyStimulus(16'h0F0F, 16'h0F0F, 1'b1, t1);
    waitResult(r, d16, o16, d5, o5);
    v_i = 1'b1; a_i = 16'hFFFF; b_i = 16'hFFFF; last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_ready", 32'(ready16), 32'd0);
      checkOutput("bp_v", 32'(v16), 32'd1);
      checkOutput("bp_data", 32'(data16), 32'd16);
      @(posedge clk);
      #1;
    end
    yumiMode = 1;
    @(negedge clk);
    yc = cyc;
    checkOutput("bp_yumi_v", 32'(yumi_i), 32'd1);
    @(posedge clk);
    #1;
    yumiMode = 0;
    @(negedge clk);
    checkOutput("bp_after_cycle", 32'(cyc - yc), 32'd1);
    checkOutput("bp_after_ready", 32'(ready16), 32'd1);
    checkOutput("bp_after_v", 32'(v16), 32'd0);
    @(posedge clk);
    #1;
    yumiMode = 1;
    applyStimulus(16'h0000, 16'h0000, 1'b1, t1);
    waitResult(r, d16, o16, d5, o5);
    checkOutput("bp_vec_data", 32'(d16), 32'd32);
    checkOutput("bp_vec_ovf", 32'(o16), 32'd0);

    // Overflow in the 5-bit instance: 16 + 16.
    applyStimulus(16'h1234, 16'h1234, 1'b0, t1);
    applyStimulus(16'hBEEF, 16'hBEEF, 1'b1, t2);
    waitResult(r, d16, o16, d5, o5);
    checkOutput("ovf_data16", 32'(d16), 32'd32);
`ifdef BSG_XNOR_POPC_ACC_SAT_EN
    checkOutput("ovf_data5", 32'(d5), 32'd31);
`else
    checkOutput("ovf_data5", 32'(d5), 32'd0);
`endif
    checkOutput("ovf_flag5", 32'(o5), 32'd1);

    // Reset mid-vector discards the partial sum.
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, t1);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, t2);
    pulseReset();
    @(negedge clk);
    checkOutput("midrst_ready", 32'(ready16), 32'd1);
    checkOutput("midrst_v", 32'(v16), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, t1);
    waitResult(r, d16, o16, d5, o5);
    checkOutput("midrst_data", 32'(d16), 32'd16);
    checkOutput("midrst_ovf5", 32'(o5), 32'd0);

    // Reset with a pending result drops it.
    yumiMode = 0;
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, t1);
    waitResult(r, d16, o16, d5, o5);
    pulseReset();
    @(negedge clk);
    checkOutput("pendrst_v", 32'(v16), 32'd0);
    checkOutput("pendrst_data", 32'(data16), 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with a random consumer.
    yumiMode = 2;
    for (int i = 0; i < 300; i++) begin
      rnd = $urandom;
      a = rnd[15:0];
      rnd = $urandom;
      case (rnd[17:16])
        2'd0:    b = rnd[15:0];
        2'd1:    b = a;
        2'd2:    b = ~a;
        default: b = a ^ (16'h1 << rnd[3:0]);
      endcase
      applyStimulus(a, b, ($urandom_range(0, 3) == 0), t1);
      if ($urandom_range(0, 3) == 0) idle(1);
      if (i == 150) pulseReset();
    end

    yumiMode = 1;
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_xnor_popcount_acc.md
# bsg_xnor_popcount_acc

Parametrised XNOR-popcount accumulator: each accepted beat bitwise-XNORs two `width_p`-bit operands, counts matching bits, and adds the count into an accumulator. A multi-beat vector ends on a beat flagged `last_i`; the finished sum is presented on a valid/yumi output. The block sits in the binary-neural-net / similarity datapath as the sequential, streaming successor to the bare bitwise XNOR cell.

## Interface
- `width_p`, default 16: operand width in bits; must be ≥ 1.
- `acc_width_p`, default 16: accumulator and result width; must be ≥ `$clog2(width_p+1)` (elaboration-time assertion).
- `clk_i` input 1: clock.
- `reset_i` input 1: synchronous, active-high reset.
- `v_i` input 1: input beat valid.
- `ready_o` output 1: block can accept a beat; a beat transfers when `v_i & ready_o`.
- `a_i` input `width_p`: operand A.
- `b_i` input `width_p`: operand B.
- `last_i` input 1: the beat is the final beat of the current vector.
- `v_o` output 1: result valid.
- `data_o` output `acc_width_p`: accumulated match count for the completed vector.
- `overflow_o` output 1: the completed vector's sum exceeded `2^acc_width_p - 1`; qualified by `v_o`.
- `yumi_i` input 1: consumer takes the result; legal only while `v_o` = 1.

## Operation
- Stage P (count register): on transfer, `pop_r <= popcount(~(a_i ^ b_i))` (width `$clog2(width_p+1)`), `last_r <= last_i`, `pv_r <= 1`. With no transfer, `pv_r <= 0`.
- Stage A (accumulate): when `pv_r` = 1, `sum = (first_r ? 0 : acc_r) + pop_r`, zero-extended to `acc_width_p`. A carry out of `acc_width_p` sets the sticky flag `ovf_r`.
  - `last_r` = 0: `acc_r <= sum`, `first_r <= 0`.
  - `last_r` = 1: `data_o <= sum`, `overflow_o <= ovf_r | carry`, `v_o <= 1`, `first_r <= 1`, `ovf_r <= 0`.
- Output holds `data_o` and `overflow_o` stable while `v_o` = 1. On `yumi_i`, `v_o <= 0`.
- `ready_o = ~v_o & ~(pv_r & last_r)`. This is combinational from registers only and does not depend on `v_i` or `yumi_i`. As a result, Stage A never receives a last beat while a result is pending.
- Non-last beats stream at one per cycle, including across the boundary into a new vector once the output is free.
- A beat with `last_i` = 1 as the first beat forms a single-beat vector.
- Reset (at any time, including mid-vector or with a pending result):
  - `pv_r`, `v_o`, `acc_r`, `ovf_r`, `overflow_o` = 0; `data_o` = 0; `first_r` = 1; `ready_o` = 1 in the first cycle after reset.
  - Any partial sum and any unconsumed result are discarded.

## Timing
- Latency: a last beat transferred in cycle t produces `v_o` = 1 in cycle t+2.
- `ready_o` is 0 in cycle t+1 and stays 0 until the cycle after `yumi_i`.
- `yumi_i` in cycle u gives `v_o` = 0 and `ready_o` = 1 in cycle u+1.
- Throughput: an N-beat vector completes in N cycles, plus 2 cycles, plus the consumer hold time.
- `yumi_i` asserted while `v_o` = 0 is a protocol violation; the bench flags it and the RTL ignores it.

## Configuration
- `BSG_XNOR_POPC_ACC_SAT_EN` defined: on carry out, the accumulator and result clamp to `2^acc_width_p - 1` and stay clamped for the rest of the vector. `overflow_o` is set as specified above.
- Not defined: the sum wraps modulo `2^acc_width_p`; `overflow_o` is still set.

## Test plan
- Single beat, `a_i`=`b_i`=16'hFFFF, `last_i`=1, `yumi_i` tied high → `v_o` at t+2, `data_o`=16, `overflow_o`=0.
- Single beat, `a_i`=16'h00FF, `b_i`=16'h0000, `last_i`=1 → `data_o`=8.
- Three-beat vector, back to back:
  - beat 1: `a_i`=`b_i`=16'h1234 → count 16;
  - beat 2: `a_i`=16'hAAAA, `b_i`=16'h5555 → count 0;
  - beat 3: `a_i`=16'hF0F0, `b_i`=16'hF000, `last_i`=1 → count 12;
  - expected: `data_o`=28, `ready_o` high during all three beats.
- Backpressure: a result is pending and `yumi_i` is held low 5 cycles with `v_i`=1 → `ready_o`=0 throughout and `data_o` stable. The next vector's first beat transfers in the cycle after `yumi_i`.
- Overflow, `acc_width_p`=5, `width_p`=16, two beats of equal operands (16 + 16 = 32):
  - macro not defined → `data_o`=0, `overflow_o`=1;
  - macro defined → `data_o`=31, `overflow_o`=1.
- Reset mid-vector after two non-last beats, then a single-beat vector with 16'hFFFF/16'hFFFF → `data_o`=16 (no stale partial sum). A reset with a pending result gives `v_o`=0 the next cycle.
